sample_packer: RTL and testbench
================================

// Module: sample_packer
// PURPOSE
//  Sits directly downstream of the decimating downsampler. Consumes its sparse
//  (data, dv) sample stream and packs N consecutive samples into one wide word.
//  Buffers completed words in a small show-ahead FIFO with a valid/ready output
//  port, so a bursty consumer (bus master, DMA, wide memory) can stall without
//  back-pressuring the free-running downsampler.
// PARAMETERS
//  dw     8   sample width, bits (>=1)
//  n      4   samples per packed word (>=2)
//  depth  4   FIFO depth in words (power of 2, >=2)
// PORTS
//  clk        in   1               rising-edge clock
//  reset      in   1               synchronous, active-high reset
//  data_in    in   dw              sample from downsampler
//  dv         in   1               data_in valid, 1-cycle qualifier, no back-pressure
//  out_data   out  n*dw            FIFO head word; first sample in bits [dw-1:0]
//  out_valid  out  1               out_data holds a word
//  out_ready  in   1               consumer accepts; pop when out_valid&&out_ready
//  fill       out  $clog2(depth)+1 words currently stored
//  overflow   out  1               1-cycle pulse: completed word dropped
//  ovf_count  out  16              only with SAMPLE_PACKER_OVF_CNT_EN (see CONFIGURATION)
// BEHAVIOUR
//  - One clock domain; reset is synchronous and active-high, sampled on clk rising.
//  - Reset state: lane=0, partial word=0, FIFO empty.
//    out_valid=0, out_data=0, fill=0, overflow=0, ovf_count=0.
//  - Reset mid-word or with FIFO occupied discards everything; no word is emitted.
//  - Lane counter 0..n-1 advances only on dv=1; wraps n-1 -> 0. dv=0 holds all state.
//  - On dv at lane k<n-1: data_in is stored at partial[k*dw +: dw].
//  - On dv at lane n-1: word {data_in, partial[(n-1)*dw-1:0]} is pushed the same edge.
//    The partial register is not cleared; stale lanes are overwritten before reuse.
//  - Latency: last-sample dv edge -> out_valid=1 next cycle, if the FIFO was empty.
//  - out_data is registered show-ahead: valid in the same cycle out_valid=1.
//    It is stable while out_valid=1 and out_ready=0.
//  - Pop: on out_valid&&out_ready, the head advances.
//    out_valid drops the next cycle if fill becomes 0.
//  - Push+pop same edge: both take effect, fill unchanged. Legal also when full.
//  - Push when fill==depth and no pop: word dropped, FIFO contents intact.
//    overflow=1 for exactly that one cycle (the cycle after the edge).
//    Lane counter still wraps to 0, so packing stays sample-aligned.
//  - Pop with FIFO empty is impossible (out_valid=0); out_ready is ignored.
//  - Read/write pointers are $clog2(depth) bits with natural wrap.
//    fill = push count minus pop count, range 0..depth.
// CONFIGURATION
//  `SAMPLE_PACKER_OVF_CNT_EN defined:
//    adds output port ovf_count[15:0], reset to 0.
//    Increments on each dropped word and saturates at 16'hFFFF.
//  Undefined: the port and counter do not exist; overflow pulse behaviour is identical.
// TESTING
//  1. dw=8,n=4: dv on samples 11,22,33,44 with out_ready=1
//     -> one cycle after dv(44): out_valid=1, out_data=32'h44332211, fill=1.
//  2. Samples spaced 4 cycles apart (downsampler r=4), 8 samples, out_ready=1
//     -> two words emitted in order, each 1 cycle after its 4th sample.
//  3. out_ready=0, 5 full words pushed (depth=4)
//     -> fill=4. 5th word dropped, overflow pulses once, first 4 words intact.
//     -> With SAMPLE_PACKER_OVF_CNT_EN: ovf_count=1.
//  4. FIFO full, out_ready=1 on the same edge a 4th sample arrives
//     -> no overflow, fill stays 4, pop order preserved.
//  5. Reset asserted after 2 of 4 samples, then 4 new samples A1..A4
//     -> no output before the new word. Word = {A4,A3,A2,A1}; old samples never appear.
//  6. out_ready toggled randomly for 64 words
//     -> output sequence equals the golden packed stream.
//     -> out_data never changes while out_valid=1 and out_ready=0.

Source files
------------

// File: rtl/sample_packer_if.sv
// Sample-in / word-out handshake bundle for sample_packer.
// master drives samples and out_ready; slave is the packer.
interface sample_packer_if #(
  parameter int dw = 8,
  parameter int n  = 4
) ();
  logic [dw-1:0]   data_in;
  logic            dv;
  logic [n*dw-1:0] out_data;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output data_in, dv, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  data_in, dv, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/sample_packer.sv
// Packs n dv-qualified samples into one word and buffers words in a
// show-ahead FIFO with a valid/ready output.
// Ports: clk, reset (sync, active high), bus (slave: data_in/dv in,
// out_data/out_valid out, out_ready in), fill (words stored),
// overflow (1-cycle pulse on dropped word), ovf_count (saturating
// drop counter, only when SAMPLE_PACKER_OVF_CNT_EN is defined).
module sample_packer #(
  parameter int dw    = 8,
  parameter int n     = 4,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  sample_packer_if.slave           bus,
  output logic [$clog2(depth):0]   fill,
`ifdef SAMPLE_PACKER_OVF_CNT_EN
  output logic [15:0]              ovf_count,
`endif
  output logic                     overflow
);

  localparam int LW = $clog2(n);
  localparam int AW = $clog2(depth);
  localparam int FW = AW + 1;
  localparam int WW = n * dw;
  localparam int PW = (n - 1) * dw;

  logic [LW-1:0] lane_q, lane_d;
  logic [PW-1:0] part_q, part_d;
  logic [WW-1:0] mem_q [depth];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          ovf_q, ovf_d;

  logic          last;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          drop;
  logic [WW-1:0] word;

  always_comb begin
    last  = (lane_q == LW'(n - 1));
    push  = bus.dv && last;
    pop   = (fill_q != '0) && bus.out_ready;
    // a full FIFO still accepts when the head leaves on the same edge
    wr_en = push && ((fill_q != FW'(depth)) || pop);
    drop  = push && !wr_en;
    word  = {bus.data_in, part_q};

    lane_d = lane_q;
    part_d = part_q;
    if (bus.dv) begin
      if (last) begin
        lane_d = '0;
      end else begin
        lane_d = lane_q + LW'(1);
        part_d[int'(lane_q)*dw +: dw] = bus.data_in;
      end
    end

    wr_d   = wr_q + AW'(wr_en);
    rd_d   = rd_q + AW'(pop);
    fill_d = fill_q + FW'(wr_en) - FW'(pop);
    ovf_d  = drop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q <= '0;
      part_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      lane_q <= lane_d;
      part_q <= part_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fill_q <= fill_d;
      ovf_q  <= ovf_d;
    end
  end

  // storage needs no reset: out_data is masked while empty
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem_q[wr_q] <= word;
    end
  end

`ifdef SAMPLE_PACKER_OVF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (drop && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ovf_count = cnt_q;
`endif

  assign bus.out_valid = (fill_q != '0);
  assign bus.out_data  = bus.out_valid ? mem_q[rd_q] : '0;
  assign fill          = fill_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_sample_packer.sv
// Directed + random bench for sample_packer with a queue scoreboard
// and a per-cycle reference model sampled on the falling edge.
`define CHK(t, o, e) begin n_cmp++; assert ((o) === (e)) else begin n_err++; $error("FAIL %s: got %0h want %0h", t, o, e); end end

module tb_sample_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  fill;
  logic        overflow;
`ifdef SAMPLE_PACKER_OVF_CNT_EN
  logic [15:0] ovf_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int ovf_seen = 0;
  bit rnd = 1'b0;
  bit rst_bad;

  sample_packer_if #(.dw(8), .n(4)) bus ();

  sample_packer #(.dw(8), .n(4), .depth(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .fill     (fill),
`ifdef SAMPLE_PACKER_OVF_CNT_EN
    .ovf_count(ovf_count),
`endif
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    n_err++;
    $error("FAIL watchdog: simulation timed out");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // reference model + scoreboard
  initial begin
    logic [31:0] q[$];
    logic [7:0]  mpart [3];
    int          mlane;
    bit          exp_ovf;
    bit          push;
    bit          pop;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic [31:0] w;
    logic [15:0] mcnt;
    mlane = 0; exp_ovf = 0; prev_stall = 0;
    prev_data = '0; mcnt = '0; w = '0;
    for (int i = 0; i < 3; i++) mpart[i] = '0;
    forever begin
      @(negedge clk);
      n_cmp++;
      if (fill !== 3'(q.size())) begin
        n_err++;
        $error("FAIL fill: got %0h want %0h", fill, q.size());
      end
      n_cmp++;
      if (bus.out_valid !== (q.size() != 0)) begin
        n_err++;
        $error("FAIL valid: got %0h", bus.out_valid);
      end
      n_cmp++;
      if (overflow !== exp_ovf) begin
        n_err++;
        $error("FAIL ovf: got %0h want %0h", overflow, exp_ovf);
      end
`ifdef SAMPLE_PACKER_OVF_CNT_EN
      n_cmp++;
      if (ovf_count !== mcnt) begin
        n_err++;
        $error("FAIL ovf_cnt: got %0h want %0h", ovf_count, mcnt);
      end
`endif
      n_cmp++;
      if (q.size() != 0) begin
        if (bus.out_data !== q[0]) begin
          n_err++;
          $error("FAIL head: got %0h want %0h", bus.out_data, q[0]);
        end
      end else begin
        if (bus.out_data !== 32'h0) begin
          n_err++;
          $error("FAIL idle_data: got %0h", bus.out_data);
        end
      end
      if (prev_stall) begin
        n_cmp++;
        if (bus.out_data !== prev_data) begin
          n_err++;
          $error("FAIL stable: got %0h want %0h", bus.out_data, prev_data);
        end
      end
      if (overflow === 1'b1) ovf_seen++;
      prev_stall = bus.out_valid && !bus.out_ready && !reset;
      prev_data  = bus.out_data;
      if (reset) begin
        q.delete();
        mlane = 0;
        exp_ovf = 0;
        mcnt = '0;
      end else begin
        push = 0;
        pop = (q.size() != 0) && bus.out_ready;
        exp_ovf = 0;
        if (bus.dv) begin
          if (mlane == 3) begin
            w = {bus.data_in, mpart[2], mpart[1], mpart[0]};
            mlane = 0;
            push = 1;
          end else begin
            mpart[mlane] = bus.data_in;
            mlane++;
          end
        end
        if (pop) void'(q.pop_front());
        if (push) begin
          if (q.size() < 4) begin
            q.push_back(w);
          end else begin
            exp_ovf = 1;
            if (mcnt != 16'hFFFF) mcnt++;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic smp(input logic [7:0] d);
    bus.dv = 1'b1;
    bus.data_in = d;
    step();
    bus.dv = 1'b0;
  endtask

  // stimulus
  initial begin
    int base;
    int k;
    bus.dv = 1'b0;
    bus.data_in = '0;
    bus.out_ready = 1'b1;
    step();
    step();

    n_cmp++;
    rst_bad = (bus.out_valid !== 1'b0) || (bus.out_data !== 32'h0)
           || (fill !== 3'd0) || (overflow !== 1'b0);
`ifdef SAMPLE_PACKER_OVF_CNT_EN
    rst_bad = rst_bad || (ovf_count !== 16'd0);
`endif
    if (rst_bad) begin
      n_err++;
      $error("FAIL reset state: valid=%0b data=%0h fill=%0d ovf=%0b",
             bus.out_valid, bus.out_data, fill, overflow);
    end
    reset = 1'b0;

    // back-to-back samples, immediate word
    smp(8'h11); smp(8'h22); smp(8'h33); smp(8'h44);
    `CHK("t1_valid", bus.out_valid, 1'b1)
    `CHK("t1_data", bus.out_data, 32'h44332211)
    `CHK("t1_fill", fill, 3'd1)
    repeat (3) step();

    // samples spaced 4 cycles apart
    for (int i = 1; i <= 8; i++) begin
      smp(8'(i));
      if (i == 4) begin
        `CHK("t2_w0", bus.out_data, 32'h04030201)
      end
      if (i == 8) begin
        `CHK("t2_w1", bus.out_data, 32'h08070605)
      end
      repeat (3) step();
    end

    // fill to capacity, then one dropped word
    bus.out_ready = 1'b0;
    base = ovf_seen;
    for (int i = 0; i < 20; i++) smp(8'(8'h10 + i));
    repeat (3) step();
    `CHK("t3_fill", fill, 3'd4)
    `CHK("t3_pulses", ovf_seen - base, 1)
    `CHK("t3_head", bus.out_data, 32'h13121110)
`ifdef SAMPLE_PACKER_OVF_CNT_EN
    `CHK("t3_cnt", ovf_count, 16'd1)
`endif

    // full, pop on the same edge as the completing sample
    smp(8'hC1); smp(8'hC2); smp(8'hC3);
    bus.out_ready = 1'b1;
    smp(8'hC4);
    bus.out_ready = 1'b0;
    `CHK("t4_fill", fill, 3'd4)
    `CHK("t4_ovf", overflow, 1'b0)
    `CHK("t4_head", bus.out_data, 32'h17161514)
    bus.out_ready = 1'b1;
    repeat (6) step();
    `CHK("t4_drain", fill, 3'd0)

    // reset with a word stored and a half-built word
    bus.out_ready = 1'b0;
    smp(8'h51); smp(8'h52); smp(8'h53); smp(8'h54);
    smp(8'h61); smp(8'h62);
    reset = 1'b1;
    step();
    reset = 1'b0;
    `CHK("t5_valid", bus.out_valid, 1'b0)
    `CHK("t5_fill", fill, 3'd0)
    bus.out_ready = 1'b1;
    smp(8'hA1); smp(8'hA2); smp(8'hA3);
    `CHK("t5_early", bus.out_valid, 1'b0)
    smp(8'hA4);
    `CHK("t5_word", bus.out_data, 32'hA4A3A2A1)
    repeat (3) step();

    // random consumer stalls, random sample spacing
    rnd = 1'b1;
    for (int i = 0; i < 256; i++) begin
      smp(8'($urandom));
      repeat ($urandom_range(0, 3)) step();
    end
    rnd = 1'b0;
    bus.out_ready = 1'b1;
    k = 0;
    while (k < 50 && bus.out_valid) begin
      step();
      k++;
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $error("FAIL t6_drain: wait expired after %0d cycles, fill=%0d", k, fill);
    end
    `CHK("t6_drain", bus.out_valid, 1'b0)
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`undef CHK
